// File: rtl/crc32_stream_engine.sv
// Framed CRC-32 (reflected 0x04C11DB7) over DATA_BYTES bytes/beat; crc_out updates 1 clk after a beat, done/fcs_out/crc_ok 1 clk after the last beat.
// s_ready is registered and drops for exactly the one DONE cycle; beats are otherwise accepted every cycle.
module crc32_stream_engine #(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [8*DATA_BYTES-1:0]       s_data,
  input  logic [$clog2(DATA_BYTES):0]   s_nbytes,
  input  logic                          s_first,
  input  logic                          s_last,
  output logic [31:0]                   crc_out,
  output logic [31:0]                   fcs_out,
  output logic                          done,
  output logic                          crc_ok,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int NBW = $clog2(DATA_BYTES) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        s_ready_q, s_ready_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;
  logic        crc_ok_q, crc_ok_d;
  logic        done_q, done_d;
  logic        frame_err_q, frame_err_d;

  logic        accept;
  logic        n_bad;
  logic [31:0] crc_base;
  logic [31:0] crc_sel;
  logic [31:0] stage [DATA_BYTES+1];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign accept = s_valid & s_ready_q;

  // Unrolled per-byte chain; stage[k] is the CRC after the first k bytes of the beat.
  always_comb begin
    crc_base = (state_q == ST_ACTIVE && !s_first) ? crc_q : INIT;
    stage[0] = crc_base;
    for (int k = 0; k < DATA_BYTES; k++) begin
      stage[k+1] = crc_byte(stage[k], s_data[8*k +: 8]);
    end
  end

  always_comb begin
    n_bad   = s_last && ((s_nbytes == '0) || (s_nbytes > NBW'(DATA_BYTES)));
    crc_sel = stage[DATA_BYTES];
    if (s_last && !n_bad) begin
      for (int k = 1; k < DATA_BYTES; k++) begin
        if (s_nbytes == NBW'(k)) crc_sel = stage[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    fcs_d       = fcs_q;
    crc_ok_d    = crc_ok_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (accept) begin
          if (state_q == ST_IDLE && !s_first) begin
            // Orphan beat outside a frame is dropped.
            frame_err_d = 1'b1;
          end else begin
            crc_d       = crc_sel;
            frame_err_d = n_bad | (state_q == ST_ACTIVE && s_first);
            if (s_last) begin
              state_d  = ST_DONE;
              fcs_d    = ~crc_sel;
              crc_ok_d = (crc_sel == RESIDUE);
              done_d   = 1'b1;
            end else begin
              state_d = ST_ACTIVE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      crc_q       <= INIT;
      fcs_q       <= 32'd0;
      crc_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      crc_q       <= crc_d;
      fcs_q       <= fcs_d;
      crc_ok_q    <= crc_ok_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign crc_out   = crc_q;
  assign fcs_out   = fcs_q;
  assign crc_ok    = crc_ok_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Randomised framed-stream bench for crc32_stream_engine at 4 bytes/beat with a bit-serial CRC reference and a done-driven scoreboard.
module tb_crc32_stream_engine;

  localparam int DB = 4;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [31:0] fcs;
    logic [31:0] raw;
    logic        ok;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [8*DB-1:0]   s_data;
  logic [2:0]        s_nbytes;
  logic              s_first;
  logic              s_last;
  logic [31:0]       crc_out;
  logic [31:0]       fcs_out;
  logic              done;
  logic              crc_ok;
  logic              busy;
  logic              frame_err;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int obs_err = 0;
  exp_t sb [$];

  crc32_stream_engine #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_nbytes(s_nbytes), .s_first(s_first), .s_last(s_last),
    .crc_out(crc_out), .fcs_out(fcs_out), .done(done), .crc_ok(crc_ok),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bit-serial LFSR view of the reflected CRC: each wire bit (LSb first) is fed back individually.
  function automatic logic [31:0] ref_raw(input bq_t msg);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ msg[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic void push_exp(input bq_t msg);
    exp_t e;
    e.raw = ref_raw(msg);
    e.fcs = ~e.raw;
    e.ok  = (e.raw == 32'hDEBB20E3);
    sb.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_beat(input logic [31:0] d, input logic [2:0] nb, input bit f, input bit l);
    int t;
    s_valid = 1'b1; s_data = d; s_nbytes = nb; s_first = f; s_last = l;
    t = 0;
    while (s_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, t);
    end
    @(negedge clk);
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input bq_t msg, input bit gaps, input bit badnb);
    int nbeats, rem;
    logic [31:0] d;
    logic [2:0] nb;
    bit last;
    nbeats = (msg.size() + DB - 1) / DB;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      for (int k = 0; k < DB; k++) begin
        if (b*DB + k < msg.size()) d[8*k +: 8] = msg[b*DB + k];
      end
      last = (b == nbeats - 1);
      rem  = msg.size() - b*DB;
      nb   = 3'($urandom_range(0, 7));
      if (last) begin
        nb = 3'(rem);
        if (badnb && rem == DB) begin
          nb = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
          exp_err++;
        end
        push_exp(msg);
      end
      drive_beat(d, nb, b == 0, last);
      if (!last && gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (frame_err === 1'b1) obs_err++;
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_done: got done=1, expected no result pending");
          end else begin
            e = sb.pop_front();
            chk("sb_fcs_out", fcs_out, e.fcs);
            chk("sb_crc_out", crc_out, e.raw);
            chk("sb_crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m9, m4, mres, mr;
    int len;
    m9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    m4 = '{8'h31, 8'h32, 8'h33, 8'h34};
    mres = m9;
    mres.push_back(8'h26); mres.push_back(8'h39); mres.push_back(8'hF4); mres.push_back(8'hCB);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_nbytes = '0; s_first = 1'b0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_crc_out", crc_out, 32'hFFFFFFFF);
    chk("rst_fcs_out", fcs_out, 32'd0);
    chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, s_ready}, 32'd1);

    // "123456789" beat by beat, junk in unused bytes of the last beat.
    drive_beat(32'h34333231, 3'd2, 1'b1, 1'b0);
    chk("busy_active", {31'd0, busy}, 32'd1);
    chk("crc_after_beat0", crc_out, ref_raw(m4));
    drive_beat(32'h38373635, 3'd3, 1'b0, 1'b0);
    push_exp(m9);
    drive_beat(32'hAABBCC39, 3'd1, 1'b0, 1'b1);
    chk("check_fcs", fcs_out, 32'hCBF43926);
    chk("check_raw", crc_out, 32'h340BC6D9);
    chk("check_ok", {31'd0, crc_ok}, 32'd0);
    chk("done_cycle_ready", {31'd0, s_ready}, 32'd0);
    chk("done_cycle_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("idle_ready", {31'd0, s_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("fcs_held", fcs_out, 32'hCBF43926);

    // Orphan beat in IDLE.
    exp_err++;
    drive_beat(32'h11223344, 3'd4, 1'b0, 1'b1);
    chk("orphan_err", {31'd0, frame_err}, 32'd1);
    chk("orphan_crc_kept", crc_out, 32'h340BC6D9);
    chk("orphan_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("orphan_err_pulse", {31'd0, frame_err}, 32'd0);

    send_frame(mres, 1'b0, 1'b0);
    chk("residue_raw", crc_out, 32'hDEBB20E3);
    chk("residue_ok", {31'd0, crc_ok}, 32'd1);
    @(negedge clk);

    send_frame('{8'h12, 8'hCD}, 1'b0, 1'b0);
    @(negedge clk);

    // Restart mid-frame; the abandoned frame must not produce a result.
    drive_beat(32'h34333231, 3'd4, 1'b1, 1'b0);
    exp_err++;
    send_frame(m9, 1'b0, 1'b0);
    chk("restart_fcs", fcs_out, 32'hCBF43926);

    // Next frame presented during DONE is held off one cycle.
    chk("done_backpressure", {31'd0, s_ready}, 32'd0);
    send_frame(m9, 1'b1, 1'b0);
    chk("gap_fcs", fcs_out, 32'hCBF43926);

    send_frame('{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 1'b1);
    @(negedge clk);

    // Reset mid-frame.
    drive_beat(32'h34333231, 3'd4, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_crc", crc_out, 32'hFFFFFFFF);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, s_ready}, 32'd0);
    chk("midrst_fcs", fcs_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(m9, 1'b0, 1'b0);
    chk("post_rst_fcs", fcs_out, 32'hCBF43926);

    for (int f = 0; f < 40; f++) begin
      bit bad;
      logic [31:0] raw;
      mr = {};
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) mr.push_back(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        raw = ~ref_raw(mr);
        for (int i = 0; i < 4; i++) mr.push_back(raw[8*i +: 8]);
      end
      bad = (mr.size() % DB == 0) && ($urandom_range(0, 3) == 0);
      send_frame(mr, $urandom_range(0, 1) == 1, bad);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("frame_err_count", obs_err, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
